e_md_scheduler: RTL and testbench
=================================

# e_md_scheduler

Execute-stage multiply/divide controller for the P7 pipelined MIPS core. It owns the HI/LO architectural registers and sequences multi-cycle mult/multu/div/divu operations with a cycle counter. It raises the decode-stage stall while the unit is busy. It also drops E-stage HI/LO requests that the CP0 exception path cancels.

## Interface
Parameters:
- MULT_CYCLES, 5: busy cycles for mult/multu (legal 1..31)
- DIV_CYCLES, 10: busy cycles for div/divu (legal 1..31)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low; 0 clears all state immediately
- E_md_op  in  4  E-stage op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo; 9..15 treated as none
- E_rs_val  in  32  forwarded rs operand
- E_rt_val  in  32  forwarded rt operand
- E_flush  in  1  the E-stage instruction is cancelled (exception/interrupt/eret taken this cycle)
- D_md_use  in  1  the D-stage instruction is any of ops 1..8
- E_busy  out  1  an operation is in flight
- D_md_stall  out  1  stall request to the D stage
- E_HI  out  32  HI register
- E_LO  out  32  LO register
- E_md_rdata  out  32  result for mfhi/mflo

## Operation
- States: IDLE, MUL, DIV. IDLE→MUL when op is 1/2. IDLE→DIV when op is 3/4. MUL/DIV→IDLE when the counter expires.
- A start happens when state is IDLE, E_md_op is 1..4 and E_flush=0. At that edge the block latches the operands and the op, loads the counter with N (MULT_CYCLES or DIV_CYCLES), and computes the result into pending HI/LO registers.
- Each busy cycle decrements the counter. On the edge where the counter goes 1→0, HI/LO take the pending result and the state returns to IDLE.
- mult: signed 32x32→64. multu: unsigned 32x32→64. HI = result[63:32], LO = result[31:0].
- div/divu: LO = quotient, HI = remainder.
  - Signed quotient truncates toward zero. The remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF (signed) gives LO=0x80000000, HI=0.
- A divisor of 0 still runs the full DIV_CYCLES. HI/LO are left unchanged.
- mthi/mtlo: with E_flush=0, E_HI or E_LO takes E_rs_val at the next edge, in any state.
  - If an in-flight completion lands on the same edge, the completion wins for both HI and LO.
- mfhi/mflo: E_md_rdata = current E_HI/E_LO. E_md_rdata is 0 for all other ops.
- E_flush=1 blocks every effect of the E instruction: no start, and no mthi/mtlo write. E_flush does not cancel an operation already in flight; it completes normally.
- A start request while state is not IDLE is ignored. The D stall normally prevents this case.
- D_md_stall = D_md_use & (E_busy | start-condition-this-cycle).

## Timing
- Reset values: E_HI=0, E_LO=0, E_busy=0, D_md_stall=0 (when D_md_use=0), E_md_rdata=0, state IDLE, counter 0, pending registers 0.
- Start at edge t (op present in cycle t-1):
  - E_busy=1 in cycles t .. t+N-1.
  - HI/LO are updated at edge t+N and visible in cycle t+N.
  - E_busy=0 in cycle t+N.
- D_md_stall is combinational. It is high in the start cycle and in every busy cycle while D_md_use=1. It falls in the cycle when HI/LO become valid, so a following mfhi reads the new value.
- E_busy is registered, driven directly from the state register.
- E_md_rdata is combinational from HI/LO and E_md_op.
- Reset asserted mid-operation aborts the operation: busy drops at once, no later HI/LO update, HI/LO=0.
- Back-to-back: a new start is legal in cycle t+N, giving a new start edge at t+N+1.

## Test plan
- Reset: reset=0 for 2 cycles, then 1 → E_HI=0, E_LO=0, E_busy=0, D_md_stall=0.
- mult 0xFFFFFFFF×2 → E_busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE. multu with the same operands → HI=0x00000001, LO=0xFFFFFFFE.
- div -7/2 → after 10 busy cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu 7/2 → LO=3, HI=1. div 5/0 → HI/LO unchanged, busy still 10 cycles.
- mult started with D_md_use=1 held → D_md_stall=1 for the start cycle plus 5 busy cycles, 0 afterwards. mflo in the first unstalled cycle → E_md_rdata equals the new LO.
- E_flush=1 with mult in E → E_busy stays 0. E_flush=1 with mthi 0x1234 → E_HI unchanged. The same mthi with E_flush=0 → E_HI=0x00001234 next cycle.
- Start div, assert reset=0 in busy cycle 4 → E_busy=0 immediately, HI/LO=0, no update at the original completion cycle.

Source files
------------

// File: rtl/e_md_scheduler.sv
// Execute-stage multiply/divide sequencer: owns HI/LO, runs mult/div for a fixed
// cycle count, and stalls the decode stage while a result is still pending.
module e_md_scheduler #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  E_md_op,
    input  logic [31:0] E_rs_val,
    input  logic [31:0] E_rt_val,
    input  logic        E_flush,
    input  logic        D_md_use,
    output logic        E_busy,
    output logic        D_md_stall,
    output logic [31:0] E_HI,
    output logic [31:0] E_LO,
    output logic [31:0] E_md_rdata
);

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t      state;
    logic [4:0]  cnt;
    logic [31:0] hi_q, lo_q, pend_hi, pend_lo;
    logic        pend_wr;

    logic        is_mul, is_div, start;
    logic [63:0] rs_ext, rt_ext, mul_prod;
    logic        rs_neg, rt_neg;
    logic [31:0] rs_mag, rt_mag, q_mag, r_mag, div_q, div_r;

    assign is_mul = (E_md_op == 4'd1) || (E_md_op == 4'd2);
    assign is_div = (E_md_op == 4'd3) || (E_md_op == 4'd4);
    assign start  = (state == IDLE) && (is_mul || is_div) && !E_flush;

    // Signed division runs on magnitudes so INT_MIN / -1 wraps cleanly to INT_MIN.
    always_comb begin
        if (E_md_op == 4'd1) begin
            rs_ext = {{32{E_rs_val[31]}}, E_rs_val};
            rt_ext = {{32{E_rt_val[31]}}, E_rt_val};
        end else begin
            rs_ext = {32'd0, E_rs_val};
            rt_ext = {32'd0, E_rt_val};
        end
        mul_prod = rs_ext * rt_ext;

        rs_neg = (E_md_op == 4'd3) && E_rs_val[31];
        rt_neg = (E_md_op == 4'd3) && E_rt_val[31];
        rs_mag = rs_neg ? (~E_rs_val + 32'd1) : E_rs_val;
        rt_mag = rt_neg ? (~E_rt_val + 32'd1) : E_rt_val;
        if (rt_mag == 32'd0) begin
            q_mag = 32'd0;
            r_mag = 32'd0;
        end else begin
            q_mag = rs_mag / rt_mag;
            r_mag = rs_mag % rt_mag;
        end
        div_q = (rs_neg ^ rt_neg) ? (~q_mag + 32'd1) : q_mag;
        div_r = rs_neg ? (~r_mag + 32'd1) : r_mag;
    end

    // A completing operation is assigned after mthi/mtlo so it wins on a shared edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= 5'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
            pend_wr <= 1'b0;
        end else begin
            if (!E_flush && E_md_op == 4'd7) hi_q <= E_rs_val;
            if (!E_flush && E_md_op == 4'd8) lo_q <= E_rs_val;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (is_mul) begin
                            state   <= MUL;
                            cnt     <= 5'(MULT_CYCLES);
                            pend_hi <= mul_prod[63:32];
                            pend_lo <= mul_prod[31:0];
                            pend_wr <= 1'b1;
                        end else begin
                            state   <= DIV;
                            cnt     <= 5'(DIV_CYCLES);
                            pend_hi <= div_r;
                            pend_lo <= div_q;
                            pend_wr <= (E_rt_val != 32'd0);
                        end
                    end
                end
                MUL, DIV: begin
                    cnt <= cnt - 5'd1;
                    if (cnt == 5'd1) begin
                        state <= IDLE;
                        if (pend_wr) begin
                            hi_q <= pend_hi;
                            lo_q <= pend_lo;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign E_busy     = (state != IDLE);
    assign D_md_stall = D_md_use && (E_busy || start);
    assign E_HI       = hi_q;
    assign E_LO       = lo_q;
    assign E_md_rdata = (E_md_op == 4'd5) ? hi_q :
                        (E_md_op == 4'd6) ? lo_q : 32'd0;

endmodule

// File: tb/tb_e_md_scheduler.sv
// Bench for e_md_scheduler: directed literal cases plus random traffic compared
// each cycle against a countdown-based behavioural model of HI/LO.
module tb_e_md_scheduler;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  md_op = 4'd0;
    logic [31:0] rs_val = 32'd0;
    logic [31:0] rt_val = 32'd0;
    logic        flush = 1'b0;
    logic        md_use = 1'b0;
    logic        E_busy, D_md_stall;
    logic [31:0] E_HI, E_LO, E_md_rdata;

    int total = 0;
    int bad = 0;

    // Model: architectural HI/LO plus the result waiting for its countdown to end.
    logic [31:0] m_hi = 32'd0, m_lo = 32'd0, m_phi = 32'd0, m_plo = 32'd0;
    int          m_left = 0;
    bit          m_pwr = 1'b0;
    bit          m_start;
    logic [31:0] exp_rdata;

    e_md_scheduler #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk(clk), .reset(reset), .E_md_op(md_op), .E_rs_val(rs_val),
        .E_rt_val(rt_val), .E_flush(flush), .D_md_use(md_use),
        .E_busy(E_busy), .D_md_stall(D_md_stall), .E_HI(E_HI), .E_LO(E_LO),
        .E_md_rdata(E_md_rdata)
    );

    always #5 clk = ~clk;

    function automatic bit starts(input logic [3:0] op, input logic fl, input int left);
        return (left == 0) && (op >= 4'd1) && (op <= 4'd4) && !fl;
    endfunction

    task automatic model_result(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, sp;
        logic [63:0] ua, ub, up;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'd0, a};
        ub = {32'd0, b};
        m_pwr = 1'b1;
        case (op)
            4'd1: begin sp = sa * sb; {m_phi, m_plo} = sp; end
            4'd2: begin up = ua * ub; {m_phi, m_plo} = up; end
            4'd3: begin
                if (b == 32'd0) m_pwr = 1'b0;
                else begin m_plo = 32'(sa / sb); m_phi = 32'(sa % sb); end
            end
            default: begin
                if (b == 32'd0) m_pwr = 1'b0;
                else begin m_plo = a / b; m_phi = a % b; end
            end
        endcase
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_hi = 32'd0; m_lo = 32'd0; m_phi = 32'd0; m_plo = 32'd0;
            m_left = 0; m_pwr = 1'b0;
        end else begin
            m_start = starts(md_op, flush, m_left);
            if (!flush && md_op == 4'd7) m_hi = rs_val;
            if (!flush && md_op == 4'd8) m_lo = rs_val;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0 && m_pwr) begin m_hi = m_phi; m_lo = m_plo; end
            end else if (m_start) begin
                model_result(md_op, rs_val, rt_val);
                m_left = (md_op <= 4'd2) ? MULT_N : DIV_N;
            end
        end
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%h want=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_rdata = (md_op == 4'd5) ? m_hi : (md_op == 4'd6) ? m_lo : 32'd0;
        check_output("busy", {31'd0, E_busy}, (m_left > 0) ? 32'd1 : 32'd0);
        check_output("stall", {31'd0, D_md_stall},
                     (md_use && (m_left > 0 || starts(md_op, flush, m_left))) ? 32'd1 : 32'd0);
        check_output("hi", E_HI, m_hi);
        check_output("lo", E_LO, m_lo);
        check_output("rdata", E_md_rdata, exp_rdata);
    end

    task automatic apply_stimulus(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                                  input logic fl, input logic us);
        @(posedge clk);
        #1;
        md_op = op; rs_val = rs; rt_val = rt; flush = fl; md_use = us;
    endtask

    task automatic idle(input int n, input logic us);
        repeat (n) apply_stimulus(4'd0, 32'd0, 32'd0, 1'b0, us);
    endtask

    task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] rs,
                          input logic [31:0] rt, input int n,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        apply_stimulus(op, rs, rt, 1'b0, 1'b0);
        idle(n, 1'b0);
        @(negedge clk);
        check_output({name, "_last_busy"}, {31'd0, E_busy}, 32'd1);
        idle(1, 1'b0);
        @(negedge clk);
        check_output({name, "_done"}, {31'd0, E_busy}, 32'd0);
        check_output({name, "_hi"}, E_HI, exp_hi);
        check_output({name, "_lo"}, E_LO, exp_lo);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 9));
            4: return -32'($urandom_range(1, 9));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check_output("reset_hi", E_HI, 32'd0);
        check_output("reset_lo", E_LO, 32'd0);
        check_output("reset_busy", {31'd0, E_busy}, 32'd0);
        check_output("reset_stall", {31'd0, D_md_stall}, 32'd0);

        run_op("mult", 4'd1, 32'hFFFF_FFFF, 32'd2, MULT_N, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("multu", 4'd2, 32'hFFFF_FFFF, 32'd2, MULT_N, 32'h0000_0001, 32'hFFFF_FFFE);
        run_op("div_neg", 4'd3, 32'hFFFF_FFF9, 32'd2, DIV_N, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu", 4'd4, 32'd7, 32'd2, DIV_N, 32'd1, 32'd3);
        run_op("div_zero", 4'd3, 32'd5, 32'd0, DIV_N, 32'd1, 32'd3);
        run_op("div_ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, DIV_N, 32'd0, 32'h8000_0000);

        apply_stimulus(4'd1, 32'd3, 32'd4, 1'b0, 1'b1);
        @(negedge clk);
        check_output("stall_start", {31'd0, D_md_stall}, 32'd1);
        idle(MULT_N, 1'b1);
        @(negedge clk);
        check_output("stall_busy", {31'd0, D_md_stall}, 32'd1);
        apply_stimulus(4'd6, 32'd0, 32'd0, 1'b0, 1'b1);
        @(negedge clk);
        check_output("stall_release", {31'd0, D_md_stall}, 32'd0);
        check_output("mflo_new", E_md_rdata, 32'd12);

        apply_stimulus(4'd1, 32'd5, 32'd5, 1'b1, 1'b0);
        idle(1, 1'b0);
        @(negedge clk);
        check_output("flush_mult", {31'd0, E_busy}, 32'd0);
        apply_stimulus(4'd7, 32'h1234, 32'd0, 1'b1, 1'b0);
        idle(1, 1'b0);
        @(negedge clk);
        check_output("flush_mthi", E_HI, 32'd0);
        apply_stimulus(4'd7, 32'h1234, 32'd0, 1'b0, 1'b0);
        idle(1, 1'b0);
        @(negedge clk);
        check_output("mthi", E_HI, 32'h0000_1234);

        apply_stimulus(4'd3, 32'd100, 32'd7, 1'b0, 1'b0);
        idle(3, 1'b0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_output("abort_busy", {31'd0, E_busy}, 32'd0);
        check_output("abort_hi", E_HI, 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        idle(DIV_N + 2, 1'b0);
        @(negedge clk);
        check_output("abort_no_update_hi", E_HI, 32'd0);
        check_output("abort_no_update_lo", E_LO, 32'd0);

        repeat (3000) begin
            apply_stimulus(4'($urandom_range(0, 15)), pick_operand(), pick_operand(),
                           ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)));
        end
        idle(DIV_N + 2, 1'b0);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
